// File: rtl/z80_spi_mailbox.sv
// SPI mode-0 slave exposing an 8-byte mailbox in each direction between a host MCU and the Z80.
// Optional SPI_AUTOINC_EN: the data phase repeats with an auto-incremented index for burst transfers.
module z80_spi_mailbox #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_MARKER  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [63:0] z80_to_spi_flat,
    output logic [63:0] spi_to_z80_flat,
    output logic [7:0]  spi_wr_stb,
    output logic        spi_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_END
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sck_prev_q, cs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    state_t      state_q, state_d;
    logic [7:0]  shin_q, shin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  miso_sr_q, miso_sr_d;
    logic        rw_q, rw_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] mbox_q, mbox_d;
    logic [7:0]  stb_q, stb_d;

    logic [7:0] byte_in;
    logic [2:0] idx_inc;
    logic       last_bit;

    assign byte_in  = {shin_q[6:0], mosi_s};
    assign idx_inc  = idx_q + 3'd1;
    assign last_bit = (cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        shin_d    = shin_q;
        cnt_d     = cnt_q;
        miso_sr_d = miso_sr_q;
        rw_d      = rw_q;
        idx_d     = idx_q;
        mbox_d    = mbox_q;
        stb_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    cnt_d     = '0;
                    miso_sr_d = CMD_MARKER;
                end
            end
            ST_CMD, ST_DATA: begin
                if (sck_rise) begin
                    shin_d = byte_in;
                    cnt_d  = cnt_q + 3'd1;
                    if (last_bit && state_q == ST_CMD) begin
                        rw_d      = byte_in[7];
                        idx_d     = byte_in[2:0];
                        state_d   = ST_DATA;
                        miso_sr_d = byte_in[7] ? 8'hFF : z80_to_spi_flat[{byte_in[2:0], 3'b000} +: 8];
                    end else if (last_bit) begin
                        if (rw_q) begin
                            mbox_d[{idx_q, 3'b000} +: 8] = byte_in;
                            stb_d[idx_q]                 = 1'b1;
                        end
`ifdef SPI_AUTOINC_EN
                        idx_d     = idx_inc;
                        miso_sr_d = rw_q ? 8'hFF : z80_to_spi_flat[{idx_inc, 3'b000} +: 8];
`else
                        state_d   = ST_END;
`endif
                    end
                end else if (sck_fall && cnt_q != 3'd0) begin
                    // The fall right after a byte boundary must not shift, or the freshly loaded MSB is lost.
                    miso_sr_d = {miso_sr_q[6:0], 1'b1};
                end
            end
            ST_END: begin
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied after the SCK handling so a byte completing on the CS-rise clk still commits.
        if (cs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shin_q    <= '0;
            cnt_q     <= '0;
            miso_sr_q <= '1;
            rw_q      <= 1'b0;
            idx_q     <= '0;
            mbox_q    <= '0;
            stb_q     <= '0;
        end else begin
            state_q   <= state_d;
            shin_q    <= shin_d;
            cnt_q     <= cnt_d;
            miso_sr_q <= miso_sr_d;
            rw_q      <= rw_d;
            idx_q     <= idx_d;
            mbox_q    <= mbox_d;
            stb_q     <= stb_d;
        end
    end

    assign spi_miso        = (state_q == ST_CMD || state_q == ST_DATA) ? miso_sr_q[7] : 1'b1;
    assign spi_miso_oe     = (state_q != ST_IDLE);
    assign spi_busy        = (state_q != ST_IDLE);
    assign spi_to_z80_flat = mbox_q;
    assign spi_wr_stb      = stb_q;

endmodule

// File: tb/tb_z80_spi_mailbox.sv
// Self-checking bench for z80_spi_mailbox: transaction-level mailbox model plus directed and random SPI traffic.
module tb_z80_spi_mailbox;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sck, spi_mosi, spi_cs_n;
    logic        spi_miso, spi_miso_oe, spi_busy;
    logic [63:0] z80_to_spi_flat, spi_to_z80_flat;
    logic [7:0]  spi_wr_stb;

    always #5 clk = ~clk;

    z80_spi_mailbox #(.SYNC_STAGES(2), .CMD_MARKER(8'hA5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_sck         (spi_sck),
        .spi_mosi        (spi_mosi),
        .spi_cs_n        (spi_cs_n),
        .spi_miso        (spi_miso),
        .spi_miso_oe     (spi_miso_oe),
        .z80_to_spi_flat (z80_to_spi_flat),
        .spi_to_z80_flat (spi_to_z80_flat),
        .spi_wr_stb      (spi_wr_stb),
        .spi_busy        (spi_busy)
    );

    logic [7:0] z80 [8];
    always_comb begin
        z80_to_spi_flat = '0;
        for (int unsigned i = 0; i < 8; i++) z80_to_spi_flat[8*i +: 8] = z80[i];
    end

    // Model: committed mailbox, writes expected in the current transaction, observed/expected strobes.
    logic [7:0] exp_mbox [8];
    logic [7:0] pend_val [8];
    logic [7:0] pend_v;
    logic [7:0] stb_seen [$];
    logic [7:0] exp_stb  [$];
    logic [7:0] tx_b [4];
    logic [7:0] rx_b [4];
    logic [7:0] exp_rx [4];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, req, $time);
        end
    endtask

    initial begin : cmp
        logic [7:0] got, req;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                got = spi_to_z80_flat[8*i +: 8];
                req = (pend_v[i] && got == pend_val[i]) ? pend_val[i] : exp_mbox[i];
                chk("mbox_byte", got, req);
                if (spi_wr_stb[i]) chk("stb_data", got, pend_val[i]);
            end
            chk("stb_legal", spi_wr_stb & ~pend_v, 64'd0);
            if (spi_wr_stb != 8'h00) stb_seen.push_back(spi_wr_stb);
        end
    end

    task automatic sck_bit(input logic bv, input bit cs_up, output logic rx);
        spi_mosi = bv;
        repeat (4) @(posedge clk);
        #1;
        spi_sck = 1'b1;
        if (cs_up) spi_cs_n = 1'b1;
        rx = spi_miso;
        repeat (4) @(posedge clk);
        #1;
        spi_sck = 1'b0;
    endtask

    task automatic set_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        tx_b[0] = a; tx_b[1] = b; tx_b[2] = c; tx_b[3] = d;
    endtask

    task automatic txn(input int nbytes, input int last_bits, input bit cs_at_last, input bit mutate, input int skew);
        logic [2:0] idx, cur;
        logic       rw, bv;
        logic [7:0] r;
        bit         active, full;
        int         nb;
        idx = tx_b[0][2:0];
        rw  = tx_b[0][7];
        stb_seen.delete();
        exp_stb.delete();
        exp_rx[0] = 8'hA5;
        for (int k = 1; k < nbytes; k++) begin
            cur = idx + 3'(k - 1);
`ifdef SPI_AUTOINC_EN
            active = 1'b1;
`else
            active = (k == 1);
`endif
            full = (k < nbytes - 1) || (last_bits == 8);
            exp_rx[k] = (!active || rw) ? 8'hFF : z80[cur];
            if (active && rw && full) begin
                pend_v[cur]   = 1'b1;
                pend_val[cur] = tx_b[k];
                exp_stb.push_back(8'h01 << cur);
            end
        end
        spi_cs_n = 1'b0;
        repeat (skew) @(posedge clk);
        #1;
        chk("busy_active", spi_busy, 1);
        chk("oe_active", spi_miso_oe, 1);
        for (int k = 0; k < nbytes; k++) begin
            nb = (k == nbytes - 1) ? last_bits : 8;
            r  = 8'h00;
            for (int j = 0; j < nb; j++) begin
                sck_bit(tx_b[k][7-j], cs_at_last && k == nbytes - 1 && j == nb - 1, bv);
                r[7-j] = bv;
                if (mutate && k == 1 && j == 0) z80[idx] = ~z80[idx];
            end
            rx_b[k] = r;
            if (nb == 8) chk("miso_byte", r, exp_rx[k]);
        end
        if (!cs_at_last) begin
            repeat (4) @(posedge clk);
            #1;
            spi_cs_n = 1'b1;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("busy_idle", spi_busy, 0);
        chk("oe_idle", spi_miso_oe, 0);
        chk("miso_idle", spi_miso, 1);
        chk("stb_count", stb_seen.size(), exp_stb.size());
        for (int i = 0; i < stb_seen.size() && i < exp_stb.size(); i++) chk("stb_order", stb_seen[i], exp_stb[i]);
        for (int i = 0; i < 8; i++) if (pend_v[i]) exp_mbox[i] = pend_val[i];
        pend_v = '0;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic       bv;
        logic [7:0] c;
        int         nbytes, lbits;
        rst_n = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        pend_v = '0;
        for (int i = 0; i < 8; i++) begin
            z80[i] = 8'h00; exp_mbox[i] = 8'h00; pend_val[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flat", spi_to_z80_flat, 64'd0);
        chk("rst_stb", spi_wr_stb, 0);
        chk("rst_miso", spi_miso, 1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_busy", spi_busy, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: populate a byte, then reset mid-byte
        set_tx(8'h82, 8'h77, 8'h00, 8'h00);
        txn(2, 8, 0, 0, 5);
        chk("t1_byte2", spi_to_z80_flat[23:16], 8'h77);
        spi_cs_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) sck_bit(1'b1, 0, bv);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) exp_mbox[i] = 8'h00;
        pend_v = '0;
        @(posedge clk);
        #1;
        chk("t1_flat", spi_to_z80_flat, 64'd0);
        chk("t1_stb", spi_wr_stb, 0);
        chk("t1_miso", spi_miso, 1);
        chk("t1_oe", spi_miso_oe, 0);
        chk("t1_busy", spi_busy, 0);
        spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 2: write 0x5A to byte 3
        set_tx(8'h83, 8'h5A, 8'h00, 8'h00);
        txn(2, 8, 0, 0, 4);
        chk("t2_byte3", spi_to_z80_flat[31:24], 8'h5A);
        chk("t2_rx0", rx_b[0], 8'hA5);
        chk("t2_rx1", rx_b[1], 8'hFF);
        chk("t2_nstb", stb_seen.size(), 1);
        chk("t2_stb", (stb_seen.size() > 0) ? stb_seen[0] : 8'h00, 8'h08);

        // 3: read byte 6; Z80 rewrites it mid-byte, snapshot must hold
        z80[6] = 8'h3C;
        set_tx(8'h06, 8'h00, 8'h00, 8'h00);
        txn(2, 8, 0, 1, 7);
        chk("t3_rx0", rx_b[0], 8'hA5);
        chk("t3_rx1", rx_b[1], 8'h3C);
        chk("t3_nstb", stb_seen.size(), 0);

        // 4: aborted write after 5 data bits
        set_tx(8'h81, 8'h99, 8'h00, 8'h00);
        txn(2, 8, 0, 0, 4);
        set_tx(8'h81, 8'h66, 8'h00, 8'h00);
        txn(2, 5, 0, 0, 6);
        chk("t4_byte1", spi_to_z80_flat[15:8], 8'h99);
        chk("t4_nstb", stb_seen.size(), 0);

        // CS rise coincident with final SCK rise still commits
        set_tx(8'h84, 8'hC3, 8'h00, 8'h00);
        txn(2, 8, 1, 0, 4);
        chk("cs_last_byte4", spi_to_z80_flat[39:32], 8'hC3);

        // 5: burst write starting at index 7
        set_tx(8'h87, 8'h11, 8'h22, 8'h33);
        txn(4, 8, 0, 0, 5);
        chk("t5_byte7", spi_to_z80_flat[63:56], 8'h11);
`ifdef SPI_AUTOINC_EN
        chk("t5_byte0", spi_to_z80_flat[7:0], 8'h22);
        chk("t5_byte1", spi_to_z80_flat[15:8], 8'h33);
        chk("t5_nstb", stb_seen.size(), 3);
`else
        chk("t5_byte0", spi_to_z80_flat[7:0], 8'h00);
        chk("t5_byte1", spi_to_z80_flat[15:8], 8'h99);
        chk("t5_nstb", stb_seen.size(), 1);
`endif
        chk("t5_rx3", rx_b[3], 8'hFF);

        // burst read wrapping 7 -> 0
        z80[7] = 8'hE1; z80[0] = 8'h2D;
        set_tx(8'h07, 8'h00, 8'h00, 8'h00);
        txn(3, 8, 0, 0, 4);
        chk("rd_rx1", rx_b[1], 8'hE1);
`ifdef SPI_AUTOINC_EN
        chk("rd_rx2", rx_b[2], 8'h2D);
`else
        chk("rd_rx2", rx_b[2], 8'hFF);
`endif

        // 6: random traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) z80[i] = 8'($urandom);
            c = 8'($urandom);
            set_tx(c, 8'($urandom), 8'($urandom), 8'($urandom));
            nbytes = ($urandom_range(0, 4) == 0) ? 3 : 2;
            lbits  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 8;
            txn(nbytes, lbits, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(4, 10)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
